aes_key_expander: RTL and testbench
===================================

// Module: aes_key_expander
// PURPOSE
//  Sequential AES key expansion engine for AES-128/192/256, with the key size selected per job.
//  Latches a cipher key on start and streams the expanded schedule w[0..4*(Nr+1)-1].
//  Emits one 32-bit word per cycle over a valid/ready handshake.
//  Sits between the key register file and the round-key buffer of the cipher datapath.
// PARAMETERS
//  MAX_KEY_BITS  256  widest supported key; key_in width. Legal values: 128/192/256. Modes wider than this raise err.
//  IDX_W         6    width of word_idx; must hold 59.
// PORTS
//  clk         in   1             system clock
//  n_rst       in   1             asynchronous active-low reset
//  start       in   1             1-cycle request; latches key_in and key_mode
//  key_mode    in   2             00=AES-128, 01=AES-192, 10=AES-256, 11=reserved
//  key_in      in   MAX_KEY_BITS  key, MSB-aligned; key_in[MAX-1 -: 32] is w0
//  word_out    out  32            current schedule word
//  word_idx    out  IDX_W         index i of word_out
//  word_valid  out  1             word_out/word_idx valid
//  word_ready  in   1             downstream accepts the word when valid&&ready
//  busy        out  1             job in progress
//  done        out  1             1-cycle pulse after the last word is accepted
//  err         out  1             1-cycle pulse on a rejected start
// BEHAVIOUR
//  Clocking/reset: one clock; reset is asynchronous and active-low.
//  Reset values: all outputs 0, FSM=IDLE, window regs 0.
//  Reset mid-job aborts the job; no done is produced.
//  Mode constants: Nk=4/6/8, Nr=10/12/14, total words N=44/52/60.
//  FSM states: IDLE, EMIT, FIN.
//   IDLE -> EMIT on start with a legal mode. Key words go into the Nk-deep window; i=0.
//   EMIT: word_valid=1. On handshake: i++. If i==N-1, go to FIN.
//   FIN: done=1 for one cycle, then IDLE.
//  Latency: start at cycle t -> w0 valid at t+1. Full throughput is 1 word/cycle.
//   With word_ready held 1, the last word is accepted at t+N and done is asserted at t+N+1.
//  Schedule for i<Nk: w[i]=key word i.
//  Schedule for i>=Nk: temp=w[i-1].
//   i%Nk==0: temp = SubWord(RotWord(temp)) ^ {Rcon[i/Nk],24'h0}.
//   Nk==8 && i%8==4: temp = SubWord(temp).
//   Then w[i] = w[i-Nk] ^ temp.
//  Window: a shift register of Nk words. Shift on handshake only, once i>=Nk-1.
//  Rcon: index counter j = i/Nk kept incrementally; no divider.
//  Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
//  Backpressure: while valid && !ready, word_out, word_idx and internal state hold.
//  Start while busy (EMIT/FIN): ignored, no err.
//  Start with mode 11, or a mode whose key exceeds MAX_KEY_BITS: err pulses the next cycle; remain IDLE.
//  busy = (state != IDLE).
//  Simultaneous events: start in the same cycle as done is ignored; done wins.
//  AES-128 and AES-192 use only the upper 128/192 bits of key_in; lower bits are don't-care.
// STRUCTURE
//  Package aes_pkg: key_mode_t enum; NK/NR/NWORDS lookup functions; RCON table; state_t enum.
//  Sub-module aes_sbox_word: 4 parallel combinational S-box lookups (32b in -> 32b out).
//   One instance, shared by the RotWord and no-rotate paths through an input mux.
//  Top level: FSM, i/j counters, window shift register, output register.
// TESTING
//  AES-128 FIPS-197 A.1: key 2b7e1516 28aed2a6 abf71588 09cf4f3c.
//   Expect w4=a0fafe17, w43=b6630ca6, 44 words, done at t+45.
//  AES-192 A.2: key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b.
//   Expect w6=fe0c91f7, w51=01002202.
//  AES-256 A.3: key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4.
//   Expect w8=9ba35411, w59=706c631e. Checks the i%8==4 SubWord-only path.
//  Backpressure: random word_ready on the AES-128 vector.
//   Expect the same 44 words in order, outputs stable while stalled, no duplicated or skipped idx.
//  Protocol: start mode=11 -> err pulse, busy=0.
//   Start during EMIT -> ignored; the stream is unchanged.
//  Reset: assert n_rst low at i=20 -> all outputs 0 immediately.
//   A new AES-256 job afterwards produces the correct w59.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types, mode lookups and round-constant table for the AES key expander.
package aes_pkg;

  typedef enum logic [1:0] {
    KEY_128  = 2'b00,
    KEY_192  = 2'b01,
    KEY_256  = 2'b10,
    KEY_RSVD = 2'b11
  } key_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Rcon[1..10] high bytes, Rcon[1] in the top byte.
  localparam logic [79:0] RCON_TBL = 80'h01020408102040801b36;

  function automatic logic [3:0] nk_of(key_mode_t m);
    case (m)
      KEY_192: return 4'd6;
      KEY_256: return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(key_mode_t m);
    case (m)
      KEY_192: return 4'd12;
      KEY_256: return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [5:0] nwords_of(key_mode_t m);
    case (m)
      KEY_192: return 6'd52;
      KEY_256: return 6'd60;
      default: return 6'd44;
    endcase
  endfunction

  // j is the 1-based Rcon index i/Nk; out-of-range j yields zero.
  function automatic logic [7:0] rcon(logic [3:0] j);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 1; k <= 10; k++) begin
      if (j == 4'(k)) r = RCON_TBL[79-8*(k-1) -: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Four parallel AES forward S-box lookups on a 32-bit word.
module aes_sbox_word (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  // Entry 0x00 sits in the top byte; entry x lives at bit {~x, 3'b111} downwards.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  always_comb begin
    dout = '0;
    for (int b = 0; b < 4; b++) begin
      dout[8*b +: 8] = SBOX[{~din[8*b +: 8], 3'b111} -: 8];
    end
  end

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128/192/256 key schedule generator streaming one word per handshake.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256,
  parameter int IDX_W        = 6
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    start,
  input  logic [1:0]              key_mode,
  input  logic [MAX_KEY_BITS-1:0] key_in,
  output logic [31:0]             word_out,
  output logic [IDX_W-1:0]        word_idx,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [1:0]              dbg_state
);

  // Handshake: a word transfers on any rising edge where word_valid && word_ready;
  // while word_valid && !word_ready, word_out/word_idx and all schedule state hold.

  state_t        state_q, state_d;
  logic [31:0]   win_q [8];
  logic [3:0]    nk_q;
  logic [5:0]    nwords_q;
  logic [2:0]    pos_q;   // (i+1) mod Nk: position of the next word to produce
  logic [3:0]    j_q;     // (i+1) / Nk: Rcon index for the next word
  logic [255:0]  key_ext;
  logic          mode_ok, accept_start, reject, hs, last_word;
  logic [2:0]    last_sel;
  logic [IDX_W-1:0] nxt_i;
  logic [31:0]   tail_word, sb_in, sb_out, temp, gen_word, next_out;

  assign key_ext = 256'(key_in) << (256 - MAX_KEY_BITS);

  always_comb begin
    mode_ok = 1'b0;
    case (key_mode_t'(key_mode))
      KEY_128: mode_ok = (MAX_KEY_BITS >= 128);
      KEY_192: mode_ok = (MAX_KEY_BITS >= 192);
      KEY_256: mode_ok = (MAX_KEY_BITS >= 256);
      default: mode_ok = 1'b0;
    endcase
  end

  assign accept_start = (state_q == IDLE) && start && mode_ok;
  assign reject       = (state_q == IDLE) && start && !mode_ok;
  assign hs           = (state_q == EMIT) && word_ready;
  assign last_word    = (word_idx == IDX_W'(nwords_q - 6'd1));
  assign last_sel     = 3'(nk_q - 4'd1);
  assign nxt_i        = word_idx + IDX_W'(1);
  assign tail_word    = win_q[last_sel];

  // One S-box instance serves both the RotWord path and the AES-256 SubWord-only path.
  assign sb_in = (pos_q == 3'd0) ? {tail_word[23:0], tail_word[31:24]} : tail_word;

  aes_sbox_word u_sbox (
    .din  (sb_in),
    .dout (sb_out)
  );

  always_comb begin
    temp = tail_word;
    if (pos_q == 3'd0) begin
      temp = sb_out ^ {rcon(j_q), 24'h0};
    end else if (nk_q == 4'd8 && pos_q == 3'd4) begin
      temp = sb_out;
    end
    gen_word = win_q[0] ^ temp;
    next_out = (nxt_i < IDX_W'(nk_q)) ? win_q[nxt_i[2:0]] : gen_word;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_start) state_d = EMIT;
      EMIT:    if (hs && last_word) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      nk_q     <= '0;
      nwords_q <= '0;
      pos_q    <= '0;
      j_q      <= '0;
      word_out <= '0;
      word_idx <= '0;
      err      <= 1'b0;
      for (int k = 0; k < 8; k++) win_q[k] <= '0;
    end else begin
      err <= reject;
      if (accept_start) begin
        nk_q     <= nk_of(key_mode_t'(key_mode));
        nwords_q <= nwords_of(key_mode_t'(key_mode));
        pos_q    <= 3'd1;
        j_q      <= 4'd0;
        word_out <= key_ext[255 -: 32];
        word_idx <= '0;
        for (int k = 0; k < 8; k++) win_q[k] <= key_ext[255-32*k -: 32];
      end else if (hs) begin
        word_out <= next_out;
        word_idx <= nxt_i;
        if (pos_q == last_sel) begin
          pos_q <= 3'd0;
          j_q   <= j_q + 4'd1;
        end else begin
          pos_q <= pos_q + 3'd1;
        end
        // Window holds w[i-Nk+1..i] once the key words are exhausted.
        if (nxt_i >= IDX_W'(nk_q)) begin
          for (int k = 0; k < 8; k++) begin
            win_q[k] <= (3'(k) == last_sel) ? gen_word : win_q[(k+1) & 7];
          end
        end
      end
    end
  end

  assign word_valid = (state_q == EMIT);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FIN);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander: FIPS-197 vectors, backpressure, protocol and reset.
module tb_aes_key_expander;

  localparam int W     = 32;
  localparam int IDX_W = 6;

  logic             clk;
  logic             n_rst;
  logic             start;
  logic [1:0]       key_mode;
  logic [255:0]     key_in;
  logic [31:0]      word_out;
  logic [IDX_W-1:0] word_idx;
  logic             word_valid;
  logic             word_ready;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       dbg_state;

  aes_key_expander #(.MAX_KEY_BITS(256), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .key_mode   (key_mode),
    .key_in     (key_in),
    .word_out   (word_out),
    .word_idx   (word_idx),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   sb [256];
  logic [31:0]  cap_w [64];
  int           cap_cnt;
  int           done_k;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference S-box built from GF(2^8) inversion plus the affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int n = 0; n < 8; n++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
    return (v << s) | (v >> (8 - s));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, x;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  function automatic logic [7:0] rcon_of(input int j);
    logic [7:0] r;
    r = 8'h01;
    for (int n = 1; n < j; n++) r = r[7] ? ((r << 1) ^ 8'h1b) : (r << 1);
    return r;
  endfunction

  // Scoreboard fill: straight array form of the key schedule.
  task automatic build_exp(input logic [1:0] mode, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    int nk, nw;
    nk = (mode == 2'b00) ? 4 : (mode == 2'b01) ? 6 : 8;
    nw = 4 * (nk + 6 + 1);
    exp_q.delete();
    for (int i = 0; i < nw; i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0)                 t = sub_word({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h0};
        else if (nk == 8 && i % 8 == 4)  t = sub_word(t);
        w[i] = w[i-nk] ^ t;
      end
      exp_q.push_back(w[i]);
    end
  endtask

  // Driver: one job from start to done (or to an injected reset).
  task automatic run_job(input logic [1:0] mode, input logic [255:0] key, input bit rand_ready,
                         input int inject_k, input int abort_idx);
    int nw, exp_idx;
    bit stall;
    logic [31:0] hold_w;
    logic [IDX_W-1:0] hold_i;
    build_exp(mode, key);
    nw = exp_q.size();
    cap_cnt = 0; done_k = -1; exp_idx = 0; stall = 1'b0;
    hold_w = '0; hold_i = '0;
    @(negedge clk);
    start = 1'b1; key_mode = mode; key_in = key; word_ready = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (stall) begin
        check("stall_valid", 32'(word_valid), 32'd1);
        check("stall_word", word_out, hold_w);
        check("stall_idx", 32'(word_idx), 32'(hold_i));
      end
      if (done) begin
        done_k = k;
        break;
      end
      if (k == 1) begin
        check("first_valid", 32'(word_valid), 32'd1);
        check("emit_state", 32'(dbg_state), 32'd1);
      end
      if (abort_idx >= 0 && word_valid && int'(word_idx) == abort_idx) begin
        n_rst = 1'b0;
        #1;
        check("rst_word", word_out, 32'h0);
        check("rst_idx", 32'(word_idx), 32'h0);
        check("rst_valid", 32'(word_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        @(negedge clk);
        n_rst = 1'b1;
        exp_q.delete();
        word_ready = 1'b0;
        return;
      end
      if (k == inject_k) begin
        start = 1'b1; key_mode = 2'b10; key_in = ~key;
      end
      if (k == inject_k + 1) begin
        check("busy_start_err", 32'(err), 32'd0);
        check("busy_start_busy", 32'(busy), 32'd1);
      end
      word_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      stall  = word_valid && !word_ready;
      hold_w = word_out;
      hold_i = word_idx;
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          check("overrun", 32'(word_idx), 32'hffff_ffff);
        end else begin
          check("word", word_out, exp_q.pop_front());
          check("idx", 32'(word_idx), 32'(exp_idx));
          cap_w[exp_idx] = word_out;
          exp_idx++;
          cap_cnt++;
        end
      end
    end
    word_ready = 1'b0;
    check("done_seen", 32'(done_k > 0), 32'd1);
    check("word_count", 32'(cap_cnt), 32'(nw));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    if (done_k > 0) begin
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef_cafef00d_12345678_9abcdef0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0123456789abcdef};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    n_rst = 1'b0; start = 1'b0; key_mode = 2'b00; key_in = '0; word_ready = 1'b0;
    build_sbox();
    repeat (3) @(negedge clk);
    check("reset_word", word_out, 32'h0);
    check("reset_idx", 32'(word_idx), 32'h0);
    check("reset_valid", 32'(word_valid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    check("reset_state", 32'(dbg_state), 32'h0);
    n_rst = 1'b1;
    @(negedge clk);

    // AES-128, full throughput
    run_job(2'b00, KEY128, 1'b0, -1, -1);
    check("a128_done_cycle", 32'(done_k), 32'd45);
    check("a128_w4", cap_w[4], 32'ha0fafe17);
    check("a128_w43", cap_w[43], 32'hb6630ca6);

    // AES-192 with a start pulse arriving mid-stream
    run_job(2'b01, KEY192, 1'b0, 10, -1);
    check("a192_done_cycle", 32'(done_k), 32'd53);
    check("a192_w6", cap_w[6], 32'hfe0c91f7);
    check("a192_w51", cap_w[51], 32'h01002202);

    // AES-256, exercises the SubWord-only path
    run_job(2'b10, KEY256, 1'b0, -1, -1);
    check("a256_done_cycle", 32'(done_k), 32'd61);
    check("a256_w8", cap_w[8], 32'h9ba35411);
    check("a256_w59", cap_w[59], 32'h706c631e);

    // AES-128 under random backpressure
    run_job(2'b00, KEY128, 1'b1, -1, -1);
    check("bp_w43", cap_w[43], 32'hb6630ca6);

    // Reserved mode is rejected
    @(negedge clk);
    start = 1'b1; key_mode = 2'b11; key_in = KEY256;
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", 32'(err), 32'd1);
    check("err_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("err_clear", 32'(err), 32'd0);
    check("err_valid", 32'(word_valid), 32'd0);

    // Reset in the middle of an AES-256 job, then a clean rerun
    run_job(2'b10, KEY256, 1'b0, -1, 20);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
    end
    run_job(2'b10, KEY256, 1'b0, -1, -1);
    check("rerun_w59", cap_w[59], 32'h706c631e);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
